// File: rtl/fir_conv_engine_if.sv
// fir_conv_engine_if: sample-in / result-out valid-ready stream pair of the FIR engine
interface fir_conv_engine_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W = 16
);
  logic s_valid;
  logic s_ready;
  logic signed [DATA_W-1:0] s_data;
  logic m_valid;
  logic m_ready;
  logic signed [OUT_W-1:0] m_data;
  logic sat_flag;
  modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data, sat_flag);
  modport slave (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data, sat_flag);
endinterface

// File: rtl/fir_conv_engine.sv
// fir_conv_engine: streaming FIR convolver, one time-shared MAC, one tap per cycle
module fir_conv_engine #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int N_TAPS = 16,
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0,
  parameter int SAT_EN = 1,
  localparam int AW = $clog2(N_TAPS)
) (
  input  logic clk,
  input  logic reset,
  input  logic coef_we_i,
  input  logic [AW-1:0] coef_addr_i,
  input  logic signed [COEF_W-1:0] coef_data_i,
  input  logic clear_i,
  output logic busy_o,
  fir_conv_engine_if.slave strm
);
  localparam int PW = DATA_W + COEF_W;
  localparam logic [AW-1:0] KL = AW'(N_TAPS - 1);
  localparam logic [AW:0] NT = (AW+1)'(N_TAPS);
  localparam logic signed [ACC_W:0] OMAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] OMIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [ACC_W:0] RND = ((ACC_W+1)'(1) << SHIFT) >> 1;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state_q, state_d;
  logic signed [DATA_W-1:0] dl_q [N_TAPS];
  logic signed [COEF_W-1:0] h_q [N_TAPS];
  logic [AW-1:0] wp_q, rp_q, k_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [OUT_W-1:0] m_data_q, m_data_d;
  logic sat_q, sat_d, last;
  logic signed [PW-1:0] prod;
  logic signed [ACC_W:0] sum, r;

  assign strm.s_ready = (state_q == IDLE) & ~coef_we_i & ~clear_i & ~reset;
  assign strm.m_valid = state_q == OUT;
  assign strm.m_data = m_data_q;
  assign strm.sat_flag = sat_q;
  assign busy_o = state_q != IDLE;

  // MAC datapath, output rounding/saturation of the final sum, and next state
  always_comb begin
    prod = h_q[k_q] * dl_q[rp_q];
    acc_d = acc_q + {{(ACC_W-PW){prod[PW-1]}}, prod};
    sum = {acc_d[ACC_W-1], acc_d} + RND;
    r = sum >>> SHIFT;
    sat_d = (SAT_EN != 0) && (r > OMAX || r < OMIN);
    m_data_d = sat_d ? (r[ACC_W] ? OMIN[OUT_W-1:0] : OMAX[OUT_W-1:0]) : r[OUT_W-1:0];
    last = k_q == KL;
    state_d = state_q == IDLE ? ((strm.s_valid & strm.s_ready) ? MAC : IDLE) :
              state_q == MAC ? (last ? OUT : MAC) :
              (strm.m_ready ? IDLE : OUT);
  end

  // state, delay line, coefficients and accumulator; rp_q walks backwards from the newest sample
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wp_q <= '0;
      rp_q <= '0;
      k_q <= '0;
      acc_q <= '0;
      m_data_q <= '0;
      sat_q <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) begin
        dl_q[i] <= '0;
        h_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (clear_i) begin
          for (int i = 0; i < N_TAPS; i++) dl_q[i] <= '0;
          wp_q <= '0;
        end else if (coef_we_i) begin
          if ({1'b0, coef_addr_i} < NT) h_q[coef_addr_i] <= coef_data_i;
        end else if (strm.s_valid) begin
          dl_q[wp_q] <= strm.s_data;
          rp_q <= wp_q;
          wp_q <= wp_q == KL ? '0 : wp_q + 1'b1;
          acc_q <= '0;
          k_q <= '0;
        end
      end
      if (state_q == MAC) begin
        acc_q <= acc_d;
        k_q <= last ? '0 : k_q + 1'b1;
        rp_q <= rp_q == '0 ? KL : rp_q - 1'b1;
        if (last) begin
          m_data_q <= m_data_d;
          sat_q <= sat_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_fir_conv_engine.sv
// tb_fir_conv_engine: four engine configurations checked against a plain-arithmetic FIR model
module tb_fir_conv_engine;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic we [4];
  logic clr [4];
  logic sv [4];
  logic mr [4];
  logic sr [4];
  logic mv [4];
  logic sf [4];
  logic bz [4];
  logic [15:0] md [4];
  logic [3:0] addr;
  logic [7:0] cdata;
  logic [7:0] sdata;

  int nt [4] = '{4, 4, 16, 5};
  int shv [4] = '{0, 0, 0, 2};
  bit satv [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int hm [4][16];
  int xm [4][16];

  for (genvar g = 0; g < 4; g++) begin : gd
    localparam int N = g == 2 ? 16 : g == 3 ? 5 : 4;
    fir_conv_engine_if #(.DATA_W(8), .OUT_W(16)) io ();
    assign io.s_valid = sv[g];
    assign io.s_data = sdata;
    assign io.m_ready = mr[g];
    assign sr[g] = io.s_ready;
    assign mv[g] = io.m_valid;
    assign md[g] = io.m_data;
    assign sf[g] = io.sat_flag;
    fir_conv_engine #(
      .DATA_W(8), .COEF_W(8), .N_TAPS(N), .ACC_W(32), .OUT_W(16),
      .SHIFT(g == 3 ? 2 : 0), .SAT_EN(g == 1 ? 0 : 1)
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .coef_we_i(we[g]),
      .coef_addr_i(addr[$clog2(N)-1:0]),
      .coef_data_i(cdata),
      .clear_i(clr[g]),
      .busy_o(bz[g]),
      .strm(io)
    );
  end

  function automatic void model(input int d, output logic [15:0] o, output logic s);
    longint acc = 0;
    longint r;
    for (int k = 0; k < nt[d]; k++) acc += longint'(hm[d][k]) * xm[d][k];
    r = (acc + ((longint'(1) << shv[d]) >> 1)) >>> shv[d];
    s = 1'b0;
    o = r[15:0];
    if (satv[d] && r > 32767) begin o = 16'h7fff; s = 1'b1; end
    if (satv[d] && r < -32768) begin o = 16'h8000; s = 1'b1; end
  endfunction

  function automatic void push(input int d, input int x);
    for (int k = 15; k > 0; k--) xm[d][k] = xm[d][k-1];
    xm[d][0] = x;
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    for (int d = 0; d < 4; d++) begin
      total++;
      if (sr[d] !== 1'b0) begin bad++; $display("FAIL reset_s_ready[%0d] got=%b exp=0", d, sr[d]); end
    end
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      total++;
      if (mv[d] !== 1'b0 || md[d] !== 16'h0 || sf[d] !== 1'b0 || bz[d] !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs[%0d] got v=%b d=%h s=%b b=%b exp all 0", d, mv[d], md[d], sf[d], bz[d]);
      end
      for (int k = 0; k < 16; k++) begin hm[d][k] = 0; xm[d][k] = 0; end
    end
    reset = 1'b0;
  endtask

  task automatic wr_coef(input int d, input int a, input int v);
    we[d] = 1'b1;
    addr = 4'(a);
    cdata = 8'(v);
    @(posedge clk);
    @(negedge clk);
    we[d] = 1'b0;
    if (a < nt[d]) hm[d][a] = int'($signed(8'(v)));
  endtask

  task automatic flush(input int d);
    clr[d] = 1'b1;
    #1;
    total++;
    if (sr[d] !== 1'b0) begin bad++; $display("FAIL clear_s_ready[%0d] got=%b exp=0", d, sr[d]); end
    @(posedge clk);
    @(negedge clk);
    clr[d] = 1'b0;
    for (int k = 0; k < 16; k++) xm[d][k] = 0;
  endtask

  task automatic xfer(input int d, input int x, output logic [15:0] got, output logic gs);
    logic [15:0] eo;
    logic es;
    int w;
    int lat;
    push(d, int'($signed(8'(x))));
    model(d, eo, es);
    sv[d] = 1'b1;
    sdata = 8'(x);
    w = 0;
    #1;
    while (!sr[d] && w < 50) begin @(negedge clk); #1; w++; end
    @(posedge clk);
    @(negedge clk);
    sv[d] = 1'b0;
    lat = 1;
    while (!mv[d] && lat < 200) begin @(negedge clk); lat++; end
    total++;
    if (lat != nt[d] + 1) begin bad++; $display("FAIL latency[%0d] got=%0d exp=%0d", d, lat, nt[d] + 1); end
    total++;
    if (md[d] !== eo || sf[d] !== es) begin
      bad++;
      $display("FAIL result[%0d] x=%0d got=%0d/%b exp=%0d/%b", d, x, $signed(md[d]), sf[d], $signed(eo), es);
    end
    got = md[d];
    gs = sf[d];
    mr[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mr[d] = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    for (int d = 0; d < 4; d++) begin
      total++;
      if (sr[d] !== 1'b1) begin bad++; $display("FAIL idle_s_ready[%0d] got=%b exp=1", d, sr[d]); end
    end
    @(negedge clk);
  endtask

  task automatic test_impulse();
    logic [15:0] ex [5] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0};
    int xs [5] = '{1, 0, 0, 0, 0};
    logic [15:0] g;
    logic s;
    for (int k = 0; k < 4; k++) wr_coef(0, k, k + 1);
    for (int i = 0; i < 5; i++) begin
      xfer(0, xs[i], g, s);
      total++;
      if (g !== ex[i] || s !== 1'b0) begin bad++; $display("FAIL impulse[%0d] got=%0d/%b exp=%0d/0", i, g, s, ex[i]); end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] g;
    logic s;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) wr_coef(d, k, 127);
      for (int i = 0; i < 4; i++) xfer(d, -128, g, s);
      total++;
      if (d == 0 && (g !== 16'h8000 || s !== 1'b1)) begin bad++; $display("FAIL sat_clamp got=%h/%b exp=8000/1", g, s); end
      if (d == 1 && (g !== 16'h0200 || s !== 1'b0)) begin bad++; $display("FAIL sat_wrap got=%h/%b exp=0200/0", g, s); end
    end
  endtask

  task automatic test_rounding();
    logic [15:0] g;
    logic s;
    wr_coef(3, 0, 6);
    for (int k = 1; k < 5; k++) wr_coef(3, k, 0);
    xfer(3, 1, g, s);
    total++;
    if (g !== 16'd2) begin bad++; $display("FAIL round_pos got=%0d exp=2", $signed(g)); end
    xfer(3, -1, g, s);
    total++;
    if (g !== 16'hffff) begin bad++; $display("FAIL round_neg got=%0d exp=-1", $signed(g)); end
  endtask

  task automatic test_random();
    logic [15:0] g;
    logic s;
    int r;
    for (int d = 2; d < 4; d++) begin
      for (int k = 0; k < nt[d]; k++) wr_coef(d, k, int'($urandom_range(0, 255)) - 128);
      for (int i = 0; i < 40; i++) begin
        r = int'($urandom_range(0, 9));
        if (r == 0) wr_coef(d, int'($urandom_range(0, d == 3 ? 7 : 15)), int'($urandom_range(0, 255)) - 128);
        else if (r == 1) flush(d);
        else xfer(d, int'($urandom_range(0, 255)) - 128, g, s);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] eo;
    logic es;
    logic [15:0] held;
    logic [15:0] g;
    logic s;
    int w;
    int x;
    x = int'($urandom_range(0, 255)) - 128;
    push(2, x);
    model(2, eo, es);
    sv[2] = 1'b1;
    sdata = 8'(x);
    #1;
    @(posedge clk);
    @(negedge clk);
    sv[2] = 1'b0;
    we[2] = 1'b1;
    clr[2] = 1'b1;
    addr = 4'd0;
    cdata = 8'($urandom);
    #1;
    total++;
    if (sr[2] !== 1'b0 || bz[2] !== 1'b1) begin bad++; $display("FAIL mac_flags got ready=%b busy=%b exp 0/1", sr[2], bz[2]); end
    @(posedge clk);
    @(negedge clk);
    we[2] = 1'b0;
    clr[2] = 1'b0;
    w = 0;
    while (!mv[2] && w < 100) begin @(negedge clk); w++; end
    total++;
    if (mv[2] !== 1'b1 || md[2] !== eo || sf[2] !== es) begin
      bad++;
      $display("FAIL bp_result got=%0d/%b valid=%b exp=%0d/%b", $signed(md[2]), sf[2], mv[2], $signed(eo), es);
    end
    held = md[2];
    for (int i = 0; i < 10; i++) begin
      we[2] = (i % 2) == 0;
      clr[2] = (i % 2) != 0;
      addr = 4'(i);
      cdata = 8'($urandom);
      #1;
      total++;
      if (mv[2] !== 1'b1 || md[2] !== held || sr[2] !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d] got v=%b d=%h r=%b exp v=1 d=%h r=0", i, mv[2], md[2], sr[2], held);
      end
      @(posedge clk);
      @(negedge clk);
    end
    we[2] = 1'b0;
    clr[2] = 1'b0;
    mr[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mr[2] = 1'b0;
    for (int i = 0; i < 3; i++) xfer(2, int'($urandom_range(0, 255)) - 128, g, s);
  endtask

  task automatic test_back_to_back();
    int ac [$];
    logic [15:0] eq [$];
    logic es [$];
    int last = -1;
    logic [15:0] eo;
    logic eso;
    bit took;
    mr[2] = 1'b1;
    sdata = 8'($urandom);
    for (int c = 0; c < 120; c++) begin
      sv[2] = c < 80;
      #1;
      took = sv[2] && sr[2];
      if (mv[2]) begin
        total++;
        if (ac.size() == 0) begin
          bad++;
          $display("FAIL b2b_extra got=%0d exp=no result", $signed(md[2]));
        end else begin
          if (c - ac[0] != 17 || md[2] !== eq[0] || sf[2] !== es[0]) begin
            bad++;
            $display("FAIL b2b_result lat=%0d got=%0d/%b exp lat=17 %0d/%b", c - ac[0], $signed(md[2]), sf[2], $signed(eq[0]), es[0]);
          end
          void'(ac.pop_front());
          void'(eq.pop_front());
          void'(es.pop_front());
        end
      end
      if (took) begin
        if (last >= 0) begin
          total++;
          if (c - last != 18) begin bad++; $display("FAIL b2b_spacing got=%0d exp=18", c - last); end
        end
        last = c;
        push(2, int'($signed(sdata)));
        model(2, eo, eso);
        ac.push_back(c);
        eq.push_back(eo);
        es.push_back(eso);
      end
      @(posedge clk);
      @(negedge clk);
      if (took) sdata = 8'($urandom);
    end
    sv[2] = 1'b0;
    mr[2] = 1'b0;
    total++;
    if (ac.size() != 0) begin bad++; $display("FAIL b2b_missing got=%0d pending exp=0", ac.size()); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] g;
    logic s;
    int seen = 0;
    sv[0] = 1'b1;
    sdata = 8'd100;
    #1;
    @(posedge clk);
    @(negedge clk);
    sv[0] = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mv[0] !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL abort_valid got=%0d cycles exp=0", seen); end
    for (int i = 0; i < 4; i++) begin
      xfer(0, i == 0 ? 1 : 0, g, s);
      total++;
      if (g !== 16'h0) begin bad++; $display("FAIL zero_h[%0d] got=%0d exp=0", i, $signed(g)); end
    end
    for (int k = 0; k < 4; k++) wr_coef(0, k, int'($urandom_range(1, 100)));
    for (int i = 0; i < 6; i++) xfer(0, int'($urandom_range(0, 255)) - 128, g, s);
    flush(0);
    for (int i = 0; i < 4; i++) begin
      xfer(0, i == 0 ? 1 : 0, g, s);
      total++;
      if (g !== 16'(hm[0][i])) begin bad++; $display("FAIL flushed[%0d] got=%0d exp=%0d", i, $signed(g), hm[0][i]); end
    end
  endtask

  initial begin
    for (int d = 0; d < 4; d++) begin
      we[d] = 1'b0;
      clr[d] = 1'b0;
      sv[d] = 1'b0;
      mr[d] = 1'b0;
    end
    addr = '0;
    cdata = '0;
    sdata = '0;
    @(negedge clk);
    test_reset();
    test_impulse();
    test_saturation();
    test_rounding();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
